track_player: RTL and testbench

//  Playback sequencer that sits directly upstream of the track memory. It drives
//  the memory's read address and chip select, absorbs the memory's 2-cycle

---
 rtl/track_player_if.sv | 29 ++
 rtl/track_player.sv | 116 +++++++++++
 tb/tb_track_player.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/track_player_if.sv
// Signal bundle between the track player, its control source, the track memory
// and the tone generator.
interface track_player_if #(
  parameter int Width  = 8,
  parameter int AWidth = 6
);
  logic              start;
  logic              stop;
  logic              loop;
  logic [AWidth-1:0] last_addr;
  logic [Width-1:0]  mem_data;
  logic [AWidth-1:0] RAddress;
  logic              CS;
  logic [Width-1:0]  note;
  logic              note_valid;
  logic              step_pulse;
  logic              busy;
  logic              done;

  modport master (
    input  start, stop, loop, last_addr, mem_data,
    output RAddress, CS, note, note_valid, step_pulse, busy, done
  );

  modport slave (
    output start, stop, loop, last_addr, mem_data,
    input  RAddress, CS, note, note_valid, step_pulse, busy, done
  );
endinterface

// File: rtl/track_player.sv
// Playback sequencer: fetches one note per step from a 2-cycle-latency track
// memory and holds it for TickDiv cycles, with loop, stop and end-marker support.
module track_player #(
  parameter int Width     = 8,
  parameter int AWidth    = 6,
  parameter int TickDiv   = 4,
  parameter int TickWidth = 24
) (
  input logic           clock,
  input logic           reset,
  track_player_if.master bus
);
  localparam logic [Width-1:0]     EndMarker = '1;
  localparam logic [TickWidth-1:0] TickLast  = TickWidth'(TickDiv - 1);

  typedef enum logic [2:0] {IDLE, F0, F1, F2, HOLD} state_t;

  state_t               state_q;
  logic [AWidth-1:0]    raddr_q;
  logic [AWidth-1:0]    last_q;
  logic [TickWidth-1:0] cnt_q;
  logic                 cs_q;
  logic [Width-1:0]     note_q;
  logic                 valid_q;
  logic                 step_q;
  logic                 busy_q;
  logic                 done_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      raddr_q <= '0;
      last_q  <= '0;
      cnt_q   <= '0;
      cs_q    <= 1'b0;
      note_q  <= '0;
      valid_q <= 1'b0;
      step_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      step_q <= 1'b0;
      done_q <= 1'b0;
      if (state_q != IDLE && bus.stop) begin
        state_q <= IDLE;
        cs_q    <= 1'b0;
        note_q  <= '0;
        valid_q <= 1'b0;
        raddr_q <= '0;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (bus.start && !bus.stop) begin
              state_q <= F0;
              raddr_q <= '0;
              cs_q    <= 1'b1;
              busy_q  <= 1'b1;
              last_q  <= bus.last_addr;
            end
          end
          F0: state_q <= F1;
          F1: state_q <= F2;
          F2: begin
            if (bus.mem_data != EndMarker) begin
              note_q  <= bus.mem_data;
              valid_q <= |bus.mem_data;
              step_q  <= 1'b1;
              cnt_q   <= '0;
              state_q <= HOLD;
            end else if (bus.loop && raddr_q != '0) begin
              // A marker at address 0 must not refetch, or an empty track spins forever
              raddr_q <= '0;
              state_q <= F0;
            end else begin
              state_q <= IDLE;
              note_q  <= '0;
              valid_q <= 1'b0;
              cs_q    <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
          HOLD: begin
            cnt_q <= cnt_q + TickWidth'(1);
            if (cnt_q == TickLast) begin
              if (raddr_q != last_q) begin
                raddr_q <= raddr_q + AWidth'(1);
                state_q <= F0;
              end else if (bus.loop) begin
                raddr_q <= '0;
                state_q <= F0;
              end else begin
                state_q <= IDLE;
                note_q  <= '0;
                valid_q <= 1'b0;
                cs_q    <= 1'b0;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign bus.RAddress   = raddr_q;
  assign bus.CS         = cs_q;
  assign bus.note       = note_q;
  assign bus.note_valid = valid_q;
  assign bus.step_pulse = step_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
endmodule

// File: tb/tb_track_player.sv
// Bench for track_player: cycle table for the basic track, hand-written stop/reset
// sequences, and randomized tracks checked against an event-timing model.
module tb_track_player;
  localparam int TickDiv = 4;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  track_player_if #(.Width(8), .AWidth(6)) bus ();

  track_player #(.Width(8), .AWidth(6), .TickDiv(TickDiv), .TickWidth(24)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // Track memory: address register then data register, both cleared while CS is low
  logic [7:0] mem [64];
  logic [5:0] a_reg;
  logic [7:0] d_reg;
  always @(posedge clock or negedge bus.CS) begin
    if (!bus.CS) begin
      a_reg <= '0;
      d_reg <= '0;
    end else begin
      a_reg <= bus.RAddress;
      d_reg <= mem[a_reg];
    end
  end
  assign bus.mem_data = d_reg;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic load_default();
    for (int i = 0; i < 64; i++) mem[i] = 8'h11;
    mem[0] = 8'h3C;
    mem[1] = 8'h00;
    mem[2] = 8'h40;
    mem[3] = 8'hFF;
  endtask

  typedef struct {
    logic       start, stop, loop;
    logic [5:0] last;
    logic [7:0] note;
    logic       valid, step, busy, done, cs;
    logic [5:0] raddr;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input int n, input logic st, input logic sp, input logic lp,
                     input logic [5:0] la, input logic [7:0] nt, input logic v,
                     input logic s, input logic b, input logic d, input logic c,
                     input logic [5:0] ra);
    vec_t r;
    r.start = st; r.stop = sp; r.loop = lp; r.last = la; r.note = nt;
    r.valid = v; r.step = s; r.busy = b; r.done = d; r.cs = c; r.raddr = ra;
    for (int i = 0; i < n; i++) tbl.push_back(r);
  endtask

  // Event-level reference: expected note update times/values and done time
  int exp_t[$];
  int exp_n[$];

  task automatic build_exp(input int last, input bit lp, input int horizon, output int exp_done);
    int t, td, a;
    exp_t.delete();
    exp_n.delete();
    exp_done = -1;
    t = 0;
    a = 0;
    while (1) begin
      td = t + 3;
      if (td > horizon) break;
      if (mem[a] == 8'hFF) begin
        if (lp && a != 0) begin
          a = 0;
          t = td;
          continue;
        end
        exp_done = td;
        break;
      end
      exp_t.push_back(td);
      exp_n.push_back(int'(mem[a]));
      t = td + TickDiv;
      if (t > horizon) break;
      if (a != last) a++;
      else if (lp) a = 0;
      else begin
        exp_done = t;
        break;
      end
    end
  endtask

  task automatic run_model(input string tag, input int last, input bit lp,
                           input int horizon, output int max_ra);
    int exp_done, seen_done, ndone, et, en;
    build_exp(last, lp, horizon, exp_done);
    seen_done = -1;
    ndone = 0;
    max_ra = 0;
    bus.last_addr = 6'(last);
    bus.loop = lp;
    bus.start = 1'b1;
    for (int k = 0; k <= horizon; k++) begin
      tick();
      bus.start = 1'b0;
      if (int'(bus.RAddress) > max_ra) max_ra = int'(bus.RAddress);
      if (bus.step_pulse) begin
        if (exp_t.size() == 0) begin
          chk({tag, "_extra_step"}, k, -1);
        end else begin
          et = exp_t.pop_front();
          en = exp_n.pop_front();
          chk({tag, "_step_time"}, k, et);
          chk({tag, "_note"}, int'(bus.note), en);
          chk({tag, "_valid"}, int'(bus.note_valid), int'(en != 0));
        end
      end
      if (bus.done) begin
        ndone++;
        seen_done = k;
        chk({tag, "_done_idle"}, {bus.busy, bus.CS, bus.note_valid, bus.note}, 0);
      end
      if (exp_done >= 0 && k > exp_done) break;
    end
    if (bus.busy) begin
      bus.stop = 1'b1;
      tick();
      bus.stop = 1'b0;
    end
    chk({tag, "_busy_end"}, int'(bus.busy), 0);
    chk({tag, "_missing_steps"}, exp_t.size(), 0);
    chk({tag, "_done_time"}, seen_done, exp_done);
    chk({tag, "_done_count"}, ndone, int'(exp_done >= 0));
    chk({tag, "_raddr_bound"}, int'(max_ra <= last), 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int mr, r, lst;
    bit lp;
    bus.start = 1'b0;
    bus.stop = 1'b0;
    bus.loop = 1'b0;
    bus.last_addr = '0;
    load_default();
    tick();
    tick();
    chk("reset_outputs", {bus.RAddress, bus.CS, bus.note, bus.note_valid,
                          bus.step_pulse, bus.busy, bus.done}, 0);
    reset = 1'b0;
    tick();

    // start/last/loop -> note,valid,step,busy,done,cs,raddr
    add(1, 1, 0, 0, 2, 8'h00, 0, 0, 1, 0, 1, 0);
    add(2, 0, 0, 0, 2, 8'h00, 0, 0, 1, 0, 1, 0);
    add(1, 0, 0, 0, 2, 8'h3C, 1, 1, 1, 0, 1, 0);
    add(3, 0, 0, 0, 2, 8'h3C, 1, 0, 1, 0, 1, 0);
    add(3, 0, 0, 0, 2, 8'h3C, 1, 0, 1, 0, 1, 1);
    add(1, 0, 0, 0, 2, 8'h00, 0, 1, 1, 0, 1, 1);
    add(3, 0, 0, 0, 2, 8'h00, 0, 0, 1, 0, 1, 1);
    add(3, 0, 0, 0, 2, 8'h00, 0, 0, 1, 0, 1, 2);
    add(1, 0, 0, 0, 2, 8'h40, 1, 1, 1, 0, 1, 2);
    add(3, 0, 0, 0, 2, 8'h40, 1, 0, 1, 0, 1, 2);
    add(1, 0, 0, 0, 2, 8'h00, 0, 0, 0, 1, 0, 2);
    add(1, 0, 0, 0, 2, 8'h00, 0, 0, 0, 0, 0, 2);
    add(1, 1, 1, 0, 2, 8'h00, 0, 0, 0, 0, 0, 2);
    add(1, 1, 0, 0, 2, 8'h00, 0, 0, 1, 0, 1, 0);
    add(1, 1, 0, 0, 5, 8'h00, 0, 0, 1, 0, 1, 0);
    add(1, 0, 0, 0, 5, 8'h00, 0, 0, 1, 0, 1, 0);
    add(1, 0, 0, 0, 5, 8'h3C, 1, 1, 1, 0, 1, 0);
    add(2, 0, 1, 0, 5, 8'h00, 0, 0, 0, 0, 0, 0);

    foreach (tbl[i]) begin
      bus.start = tbl[i].start;
      bus.stop = tbl[i].stop;
      bus.loop = tbl[i].loop;
      bus.last_addr = tbl[i].last;
      tick();
      chk($sformatf("vec%0d", i),
          {bus.note, bus.note_valid, bus.step_pulse, bus.busy, bus.done, bus.CS, bus.RAddress},
          {tbl[i].note, tbl[i].valid, tbl[i].step, tbl[i].busy, tbl[i].done, tbl[i].cs, tbl[i].raddr});
    end
    bus.stop = 1'b0;

    // stop during the HOLD of address 1, then replay from address 0
    bus.last_addr = 6'd2;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int k = 0; k < 40 && !(bus.step_pulse && bus.RAddress == 6'd1); k++) tick();
    chk("reach_addr1", int'(bus.step_pulse && bus.RAddress == 6'd1), 1);
    tick();
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
    chk("stop_hold", {bus.busy, bus.CS, bus.note, bus.note_valid, bus.RAddress, bus.done}, 0);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    tick();
    chk("replay_note", {bus.note, bus.step_pulse, bus.RAddress}, {8'h3C, 1'b1, 6'd0});
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;

    // stop while in F1
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
    chk("stop_f1", {bus.busy, bus.CS, bus.note, bus.note_valid, bus.RAddress}, 0);
    tick();
    tick();
    tick();
    chk("stop_f1_no_step", {bus.step_pulse, bus.busy}, 0);

    // asynchronous reset while in F1
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    #2 reset = 1'b1;
    #1;
    chk("reset_mid_f1", {bus.RAddress, bus.CS, bus.note, bus.note_valid,
                         bus.step_pulse, bus.busy, bus.done}, 0);
    #1 reset = 1'b0;
    tick();

    // marker ends an over-long track; looping track; marker at address 0
    run_model("marker_end", 63, 1'b0, 480, mr);
    chk("marker_max_raddr", mr, 3);
    run_model("loop3", 2, 1'b1, 60, mr);
    chk("loop3_wrap_max", mr, 2);
    mem[0] = 8'hFF;
    run_model("empty_loop", 2, 1'b1, 30, mr);
    load_default();

    for (int n = 0; n < 8; n++) begin
      for (int i = 0; i < 64; i++) begin
        r = int'($urandom_range(0, 9));
        mem[i] = (r == 0) ? 8'hFF : (r == 1) ? 8'h00 : 8'($urandom_range(1, 254));
      end
      lst = (n == 0) ? 63 : int'($urandom_range(0, 63));
      lp = 1'($urandom_range(0, 1));
      run_model($sformatf("rnd%0d", n), lst, lp, lp ? 200 : 480, mr);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
